uart_tx_serializer_p: RTL and testbench

//  Parametrised parallel-to-serial shifter for the UART TX path. Captures one DATA_W-bit word per
//  ser_en request and presents it one bit per clk on ser_data, LSB- or MSB-first. Computes the

---
 rtl/uart_tx_serializer_p_if.sv | 29 ++
 rtl/uart_tx_serializer_p.sv | 92 +++++++++
 tb/tb_uart_tx_serializer_p.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_p_if.sv
// Word-request / serial-output bundle between the TX FSM and the serializer.
interface uart_tx_serializer_p_if #(
   parameter int unsigned DATA_W = 8
);
   logic              ser_en;
   logic [DATA_W-1:0] p_data;
   logic              ser_data;
   logic              ser_busy;
   logic              ser_done;
   logic              par_bit;

   modport master (
      output ser_en,
      output p_data,
      input  ser_data,
      input  ser_busy,
      input  ser_done,
      input  par_bit
   );

   modport slave (
      input  ser_en,
      input  p_data,
      output ser_data,
      output ser_busy,
      output ser_done,
      output par_bit
   );
endinterface

// File: rtl/uart_tx_serializer_p.sv
// Parallel-to-serial shifter for the UART TX path: one bit per clock, parity of the captured
// word, one-cycle done pulse, back-to-back words when the request stays high.
module uart_tx_serializer_p #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b0,
   parameter bit          IDLE_VAL  = 1'b0,
   parameter bit          PAR_ODD   = 1'b0
) (
   input logic                   clk,
   input logic                   rest,
   uart_tx_serializer_p_if.slave ser
);

   localparam int unsigned CntW = $clog2(DATA_W);
   localparam logic [CntW-1:0] CntMax = CntW'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              data_q, data_d;
   logic              par_q, par_d;
   logic              capture;

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         data_q  <= IDLE_VAL;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      par_d   = par_q;
      capture = 1'b0;

      unique case (state_q)
         StIdle: begin
            capture = ser.ser_en;
         end
         StShift: begin
            // Counter stops at CntMax: the edge after the last bit leaves SHIFT.
            if (cnt_q == CntMax) begin
               state_d = StDone;
               data_d  = IDLE_VAL;
            end else begin
               data_d  = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
               shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
               cnt_d   = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            capture = ser.ser_en;
            if (!ser.ser_en) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            data_d  = IDLE_VAL;
         end
      endcase

      // First bit goes straight to the output; the shift register holds the remainder.
      if (capture) begin
         state_d = StShift;
         data_d  = MSB_FIRST ? ser.p_data[DATA_W-1] : ser.p_data[0];
         shreg_d = MSB_FIRST ? (ser.p_data << 1) : (ser.p_data >> 1);
         cnt_d   = '0;
         par_d   = (^ser.p_data) ^ PAR_ODD;
      end
   end

   assign ser.ser_data = data_q;
   assign ser.ser_busy = (state_q == StShift);
   assign ser.ser_done = (state_q == StDone);
   assign ser.par_bit  = par_q;

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Directed bench for uart_tx_serializer_p: LSB-first, MSB-first and 12-bit odd-parity variants.
module tb_uart_tx_serializer_p;

   logic clk;
   logic rest;
   int   n_checks;
   int   n_fail;

   uart_tx_serializer_p_if #(.DATA_W(8))  a_bus ();
   uart_tx_serializer_p_if #(.DATA_W(8))  b_bus ();
   uart_tx_serializer_p_if #(.DATA_W(12)) c_bus ();

   uart_tx_serializer_p #(
      .DATA_W(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0), .PAR_ODD(1'b0)
   ) u_a (
      .clk  (clk),
      .rest (rest),
      .ser  (a_bus.slave)
   );

   uart_tx_serializer_p #(
      .DATA_W(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0), .PAR_ODD(1'b0)
   ) u_b (
      .clk  (clk),
      .rest (rest),
      .ser  (b_bus.slave)
   );

   uart_tx_serializer_p #(
      .DATA_W(12), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1), .PAR_ODD(1'b1)
   ) u_c (
      .clk  (clk),
      .rest (rest),
      .ser  (c_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [0:7]  exp_a5;
   logic [0:7]  exp_3c;
   logic [0:7]  exp_81;
   logic [0:11] exp_ffe;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      // Bit sequences in transmission order, index 0 sent first.
      exp_a5  = 8'b1010_0101;
      exp_3c  = 8'b0011_1100;
      exp_81  = 8'b1000_0001;
      exp_ffe = 12'b0111_1111_1111;

      a_bus.ser_en = 1'b0; a_bus.p_data = '0;
      b_bus.ser_en = 1'b0; b_bus.p_data = '0;
      c_bus.ser_en = 1'b0; c_bus.p_data = '0;
      rest = 1'b1;
      tick();
      tick();
      rest = 1'b0;
      tick();

      // Reset state
      check("rst a data", a_bus.ser_data, 0);
      check("rst a busy", a_bus.ser_busy, 0);
      check("rst a done", a_bus.ser_done, 0);
      check("rst a par", a_bus.par_bit, 0);
      check("rst c data", c_bus.ser_data, 1);
      check("rst c par", c_bus.par_bit, 0);

      // Reset mid-run: word 8'h01 (parity 1) aborted in cycle 2
      a_bus.p_data = 8'h01; a_bus.ser_en = 1'b1;
      tick();
      a_bus.ser_en = 1'b0;
      check("mid a busy c1", a_bus.ser_busy, 1);
      check("mid a data c1", a_bus.ser_data, 1);
      check("mid a par c1", a_bus.par_bit, 1);
      tick();
      rest = 1'b1;
      #1;
      check("mid rst data", a_bus.ser_data, 0);
      check("mid rst busy", a_bus.ser_busy, 0);
      check("mid rst done", a_bus.ser_done, 0);
      check("mid rst par", a_bus.par_bit, 0);
      tick();
      rest = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("idle busy %0d", i), a_bus.ser_busy, 0);
         check($sformatf("idle done %0d", i), a_bus.ser_done, 0);
         check($sformatf("idle data %0d", i), a_bus.ser_data, 0);
      end

      // LSB-first 8'hA5, single-cycle request
      a_bus.p_data = 8'hA5; a_bus.ser_en = 1'b1;
      tick();
      a_bus.ser_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         check($sformatf("a5 bit%0d", i), a_bus.ser_data, exp_a5[i]);
         check($sformatf("a5 busy%0d", i), a_bus.ser_busy, 1);
         check($sformatf("a5 done%0d", i), a_bus.ser_done, 0);
      end
      tick();
      check("a5 done c9", a_bus.ser_done, 1);
      check("a5 busy c9", a_bus.ser_busy, 0);
      check("a5 data c9", a_bus.ser_data, 0);
      check("a5 par", a_bus.par_bit, 0);
      tick();
      check("a5 done c10", a_bus.ser_done, 0);
      check("a5 busy c10", a_bus.ser_busy, 0);

      // MSB-first 8'h81, p_data cleared after capture
      b_bus.p_data = 8'h81; b_bus.ser_en = 1'b1;
      tick();
      b_bus.ser_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         if (i == 1) b_bus.p_data = 8'h00;
         check($sformatf("81 bit%0d", i), b_bus.ser_data, exp_81[i]);
      end
      tick();
      check("81 done c9", b_bus.ser_done, 1);
      check("81 par", b_bus.par_bit, 0);

      // Back-to-back: A5 then 3C with ser_en held high
      tick();
      a_bus.p_data = 8'hA5; a_bus.ser_en = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         check($sformatf("b2b a5 bit%0d", i), a_bus.ser_data, exp_a5[i]);
      end
      tick();
      check("b2b done c9", a_bus.ser_done, 1);
      check("b2b par c9", a_bus.par_bit, 0);
      a_bus.p_data = 8'h3C;
      tick();
      check("b2b busy c10", a_bus.ser_busy, 1);
      check("b2b done c10", a_bus.ser_done, 0);
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         check($sformatf("b2b 3c bit%0d", i), a_bus.ser_data, exp_3c[i]);
         check($sformatf("b2b 3c done%0d", i), a_bus.ser_done, 0);
      end
      tick();
      a_bus.ser_en = 1'b0;
      check("b2b done c18", a_bus.ser_done, 1);
      check("b2b par c18", a_bus.par_bit, 0);
      tick();
      check("b2b done c19", a_bus.ser_done, 0);
      check("b2b busy c19", a_bus.ser_busy, 0);

      // 8'hFF aborted by reset pulse in cycle 4, then resent in full
      a_bus.p_data = 8'hFF; a_bus.ser_en = 1'b1;
      tick();
      a_bus.ser_en = 1'b0;
      tick(); tick(); tick();
      check("ff busy c4", a_bus.ser_busy, 1);
      rest = 1'b1;
      #2;
      rest = 1'b0;
      check("ff abort busy", a_bus.ser_busy, 0);
      check("ff abort data", a_bus.ser_data, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("ff no done %0d", i), a_bus.ser_done, 0);
         check($sformatf("ff no busy %0d", i), a_bus.ser_busy, 0);
      end
      a_bus.ser_en = 1'b1;
      tick();
      a_bus.ser_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         check($sformatf("ff bit%0d", i), a_bus.ser_data, 1);
         check($sformatf("ff busy%0d", i), a_bus.ser_busy, 1);
      end
      tick();
      check("ff done c9", a_bus.ser_done, 1);
      check("ff par", a_bus.par_bit, 0);

      // 12-bit, odd parity, idle-high: 12'hFFE
      c_bus.p_data = 12'hFFE; c_bus.ser_en = 1'b1;
      tick();
      c_bus.ser_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i != 0) tick();
         check($sformatf("ffe bit%0d", i), c_bus.ser_data, exp_ffe[i]);
         check($sformatf("ffe busy%0d", i), c_bus.ser_busy, 1);
      end
      tick();
      check("ffe done c13", c_bus.ser_done, 1);
      check("ffe busy c13", c_bus.ser_busy, 0);
      check("ffe data c13", c_bus.ser_data, 1);
      check("ffe par", c_bus.par_bit, 0);
      tick();
      check("ffe done c14", c_bus.ser_done, 0);
      check("ffe data c14", c_bus.ser_data, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
